// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared slot encodings and address helpers for the VGA memory arbiter
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 2 * COORD_W;

  // Memory slot owner for the coming SRAM cycle
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  // Frame buffer is row-major: row in the upper half, column in the lower half
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - write buffer holding drawing-engine pixel writes in arrival order
module vga_wr_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entry storage; validity is defined by the pointers, so contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - single-port SRAM arbiter, display reads over buffered writes; option VGA_ARB_STALL_CNT_EN
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          need,
  input  logic [COORD_W-1:0]            h_need,
  input  logic [COORD_W-1:0]            v_need,
  output logic [DW-1:0]                 pix_data,
  output logic                          pix_valid,
  input  logic                          wr_req,
  input  logic [COORD_W-1:0]            wr_x,
  input  logic [COORD_W-1:0]            wr_y,
  input  logic [DW-1:0]                 wr_data,
  output logic                          wr_ack,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic                          sram_we,
  output logic                          sram_oe,
  output logic [DW-1:0]                 sram_wdata,
  input  logic [DW-1:0]                 sram_rdata,
`ifdef VGA_ARB_STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int EW = 2 * COORD_W + DW;

  slot_e         slot_q;
  slot_e         slot_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [EW-1:0] fifo_head;
  logic          rd_d1;

  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [DW-1:0]      head_d;

  assign {head_y, head_x, head_d} = fifo_head;

  // No pass-through when full: a same-cycle pop does not free a slot for this request
  assign wr_ack = wr_req && !fifo_full && !reset;

  vga_wr_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_ack),
    .push_data ({wr_y, wr_x, wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Slot register: the slot currently driving the SRAM pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= SLOT_IDLE;
    else       slot_q <= slot_d;
  end

  // Slot choice: display always wins, writes drain only on cycles it leaves free
  always_comb begin
    slot_d   = SLOT_IDLE;
    fifo_pop = 1'b0;
    if (need) begin
      slot_d = SLOT_READ;
    end else if (!fifo_empty) begin
      slot_d   = SLOT_WRITE;
      fifo_pop = 1'b1;
    end
  end

  assign sram_oe = (slot_q == SLOT_READ);
  assign sram_we = (slot_q == SLOT_WRITE);

  // Address/data launch registers; held through idle slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (slot_d)
        SLOT_READ:  sram_addr <= pix_addr(h_need, v_need);
        SLOT_WRITE: begin
          sram_addr  <= pix_addr(head_x, head_y);
          sram_wdata <= head_d;
        end
        default: ;
      endcase
    end
  end

  // Read return: SRAM data arrives the cycle after oe, captured one edge later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_d1     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      rd_d1     <= sram_oe;
      pix_valid <= rd_d1;
      pix_data  <= rd_d1 ? sram_rdata : '0;
    end
  end

`ifdef VGA_ARB_STALL_CNT_EN
  // Saturating count of cycles the drawing engine was refused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (wr_req && !wr_ack && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
- REQ-001 SHALL have parameter DW, default 8, meaning pixel/SRAM data width.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning write-FIFO entries (power of 2, ≥2).
- REQ-003 SHALL have port clk  input  1  single clock for all logic.
- REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port need  input  1  display requests a pixel this cycle.
- REQ-006 SHALL have port h_need, v_need  input  10 each  pixel column/row requested.
- REQ-007 SHALL have port pix_data  output  DW  pixel returned to the display.
- REQ-008 SHALL have port pix_valid  output  1  pix_data holds a fetched pixel.
- REQ-009 SHALL have port wr_req  input  1  drawing engine offers a pixel write.
- REQ-010 SHALL have port wr_x, wr_y  input  10 each  write column/row.
- REQ-011 SHALL have port wr_data  input  DW  write pixel value.
- REQ-012 SHALL have port wr_ack  output  1  write accepted this cycle.
- REQ-013 SHALL have port sram_addr  output  20  address, {row, column}.
- REQ-014 SHALL have ports sram_we, sram_oe  output  1 each  SRAM write/read strobes.
- REQ-015 SHALL have port sram_wdata  output  DW  SRAM write data.
- REQ-016 SHALL have port sram_rdata  input  DW  SRAM read data, valid one cycle after sram_oe address.
- REQ-017 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  current write-FIFO occupancy.

Function
- REQ-018 SHALL register a slot state each cycle: IDLE, READ or WRITE.
- REQ-019 SHALL select READ whenever need=1, regardless of FIFO contents (display absolute priority).
- REQ-020 SHALL select WRITE when need=0 and FIFO non-empty; otherwise IDLE.
- REQ-021 SHALL, in READ, drive sram_addr={v_need,h_need}, sram_oe=1, sram_we=0, registered (one-cycle issue latency).
- REQ-022 SHALL, in WRITE, pop the FIFO head and drive sram_addr={wr_y,wr_x}, sram_wdata, sram_we=1, sram_oe=0, registered.
- REQ-023 SHALL, in IDLE, drive sram_we=0, sram_oe=0, sram_addr held.
- REQ-024 SHALL capture sram_rdata into pix_data and assert pix_valid exactly 3 clk after the corresponding need cycle (fixed latency); otherwise pix_valid=0, pix_data=0.
- REQ-025 SHALL assert wr_ack combinationally iff wr_req=1 and FIFO not full; push on wr_ack.
- REQ-026 SHALL, when full with a pop in the same cycle, still deassert wr_ack (no pass-through).
- REQ-027 SHALL allow simultaneous push and pop when not full; occupancy then unchanged.
- REQ-028 SHALL preserve write order; FIFO pointers wrap modulo FIFO_DEPTH.
- REQ-029 SHALL never drop a pending write when need interrupts; head stays until a WRITE slot.

Reset
- REQ-030 SHALL, on reset assertion, immediately force state IDLE, sram_we=0, sram_oe=0, sram_addr=0, sram_wdata=0, pix_valid=0, pix_data=0, FIFO empty (fifo_level=0), wr_ack=0.
- REQ-031 SHALL discard FIFO contents and in-flight reads when reset asserts mid-operation.

Configuration
- REQ-032 SHALL, with VGA_ARB_STALL_CNT_EN defined, add output stall_cnt (16 bits): counts cycles with wr_req=1 and wr_ack=0, saturating at 0xFFFF, cleared by reset.
- REQ-033 SHALL, without VGA_ARB_STALL_CNT_EN, omit stall_cnt port and logic entirely.

Structure
- REQ-034 SHALL place slot-state encodings (IDLE=0, READ=1, WRITE=2) and address-width constant in shared package vga_pkg.
- REQ-035 SHALL implement the write buffer as sub-module vga_wr_fifo (push/pop/full/empty/level).

Verification
- REQ-036 SHALL check: need=1 at (h=5,v=7), sram_rdata=0xA5 → sram_addr=0x01C05 next cycle, pix_data=0xA5, pix_valid=1 three cycles after need.
- REQ-037 SHALL check: need=0, one write (x=3,y=2,d=0x11) → wr_ack same cycle, sram_we=1, addr=0x00803, wdata=0x11 two cycles later.
- REQ-038 SHALL check: need=1 continuously, 5 write requests at FIFO_DEPTH=4 → 4 acks, 5th wr_ack=0, no sram_we; on need=0 four writes in order.
- REQ-039 SHALL check: FIFO full, need=0, wr_req held → wr_ack=0 on pop cycle, 1 the cycle after.
- REQ-040 SHALL check: reset asserted with fifo_level=3 and reads in flight → all outputs zero immediately, no later pix_valid or sram_we.
- REQ-041 SHALL check (VGA_ARB_STALL_CNT_EN): 10 stalled wr_req cycles → stall_cnt=10; forced to 0xFFFF saturates.
